// File: rtl/msk_g16inv_seq.sv
// Masked GF(16) inverter (y = x^14) built around a single HPC1 multiplier.
// A 7-state sequencer feeds the multiplier from registered shares only.

`ifndef DEFAULTSHARES
`define DEFAULTSHARES 2
`endif

module msk_g16inv_seq #(
    parameter int unsigned d       = `DEFAULTSHARES,
    parameter int unsigned hpc1rnd = d * (d - 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [d-1:0]           in0,
    input  logic [d-1:0]           in1,
    input  logic [d-1:0]           in2,
    input  logic [d-1:0]           in3,
    input  logic [4*hpc1rnd-1:0]   rnd,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [d-1:0]           out0,
    output logic [d-1:0]           out1,
    output logic [d-1:0]           out2,
    output logic [d-1:0]           out3
);

    typedef enum logic [2:0] {IDLE, M1B, M1A, M2B, M2A, CAP, DONE} state_t;

    state_t state, state_nxt;

    logic [d-1:0][3:0] x_q, t_q, y_q;
    logic [d-1:0][3:0] x2_sh, x4_sh, x8_sh;
    logic [d-1:0][3:0] mul_a, mul_b, mul_c;

    function automatic logic [3:0] gf_sq(input logic [3:0] a);
        return {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};
    endfunction

    // Squaring is linear, so it is applied to each share independently.
    always_comb begin
        for (int unsigned s = 0; s < d; s++) begin
            x2_sh[s] = gf_sq(x_q[s]);
            x4_sh[s] = gf_sq(x2_sh[s]);
            x8_sh[s] = gf_sq(x4_sh[s]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = M1B;
            end
            M1B: begin
                mul_b     = x4_sh;
                state_nxt = M1A;
            end
            M1A: begin
                mul_a     = x2_sh;
                state_nxt = M2B;
            end
            M2B: begin
                mul_b     = x8_sh;
                state_nxt = M2A;
            end
            M2A: begin
                mul_a     = t_q;
                state_nxt = CAP;
            end
            CAP:  state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            t_q <= '0;
            y_q <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                for (int unsigned s = 0; s < d; s++)
                    x_q[s] <= {in3[s], in2[s], in1[s], in0[s]};
            end
            if (state == M2B) t_q <= mul_c;
            if (state == CAP) y_q <= mul_c;
        end
    end

    always_comb begin
        for (int unsigned s = 0; s < d; s++) begin
            out0[s] = y_q[s][0];
            out1[s] = y_q[s][1];
            out2[s] = y_q[s][2];
            out3[s] = y_q[s][3];
        end
    end

    MSKg16mul_hpc1 #(.d(d), .hpc1rnd(hpc1rnd)) u_mul (
        .clk (clk),
        .a   (mul_a),
        .b   (mul_b),
        .rnd (rnd),
        .c   (mul_c)
    );

endmodule

// HPC1 masked GF(16) multiplier: b is refreshed and registered, a arrives one
// cycle later; the registered DOM cross products are compressed per share.
module MSKg16mul_hpc1 #(
    parameter int unsigned d       = 2,
    parameter int unsigned hpc1rnd = d * (d - 1)
) (
    input  logic                 clk,
    input  logic [d-1:0][3:0]    a,
    input  logic [d-1:0][3:0]    b,
    input  logic [4*hpc1rnd-1:0] rnd,
    output logic [d-1:0][3:0]    c
);

    localparam int unsigned NPAIR = d * (d - 1) / 2;

    logic [d-1:0][3:0]         b_ref, b_q;
    logic [d-1:0][d-1:0][3:0]  p_d, p_q;

    function automatic logic [3:0] gf_mul(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] acc, sh;
        acc = '0;
        sh  = x;
        for (int unsigned i = 0; i < 4; i++) begin
            if (y[i]) acc = acc ^ sh;
            sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'b0011 : 4'b0000);
        end
        return acc;
    endfunction

    // Lower NPAIR nibbles refresh b, upper NPAIR nibbles mask the cross terms.
    always_comb begin
        int unsigned k;
        k     = 0;
        b_ref = b;
        for (int unsigned i = 0; i < d; i++) begin
            for (int unsigned j = i + 1; j < d; j++) begin
                b_ref[i] = b_ref[i] ^ rnd[4*k +: 4];
                b_ref[j] = b_ref[j] ^ rnd[4*k +: 4];
                k++;
            end
        end
    end

    always_comb begin
        int unsigned k;
        k   = NPAIR;
        p_d = '0;
        for (int unsigned i = 0; i < d; i++)
            p_d[i][i] = gf_mul(a[i], b_q[i]);
        for (int unsigned i = 0; i < d; i++) begin
            for (int unsigned j = i + 1; j < d; j++) begin
                p_d[i][j] = gf_mul(a[i], b_q[j]) ^ rnd[4*k +: 4];
                p_d[j][i] = gf_mul(a[j], b_q[i]) ^ rnd[4*k +: 4];
                k++;
            end
        end
    end

    always_ff @(posedge clk) begin
        b_q <= b_ref;
        p_q <= p_d;
    end

    always_comb begin
        for (int unsigned i = 0; i < d; i++) begin
            c[i] = '0;
            for (int unsigned j = 0; j < d; j++)
                c[i] = c[i] ^ p_q[i][j];
        end
    end

endmodule

// File: tb/tb_msk_g16inv_seq.sv
// Randomized self-checking bench for msk_g16inv_seq; d=2, 3 and 4 instances
// run in lockstep and are compared against a field-arithmetic inverse model.

module tb_msk_g16inv_seq;

    logic clk;
    logic rst, in_valid, out_ready;
    logic ir2, ir3, ir4, ov2, ov3, ov4;
    logic [3:0][1:0] x2, y2;
    logic [3:0][2:0] x3, y3;
    logic [3:0][3:0] x4, y4;
    logic [7:0]  r2;
    logic [23:0] r3;
    logic [47:0] r4;
    logic [3:0]  u2, u3, u4;

    int checks   = 0;
    int failures = 0;

    msk_g16inv_seq #(.d(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
        .in0(x2[0]), .in1(x2[1]), .in2(x2[2]), .in3(x2[3]), .rnd(r2),
        .out_valid(ov2), .out_ready(out_ready),
        .out0(y2[0]), .out1(y2[1]), .out2(y2[2]), .out3(y2[3])
    );

    msk_g16inv_seq #(.d(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3),
        .in0(x3[0]), .in1(x3[1]), .in2(x3[2]), .in3(x3[3]), .rnd(r3),
        .out_valid(ov3), .out_ready(out_ready),
        .out0(y3[0]), .out1(y3[1]), .out2(y3[2]), .out3(y3[3])
    );

    msk_g16inv_seq #(.d(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
        .in0(x4[0]), .in1(x4[1]), .in2(x4[2]), .in3(x4[3]), .rnd(r4),
        .out_valid(ov4), .out_ready(out_ready),
        .out0(y4[0]), .out1(y4[1]), .out2(y4[2]), .out3(y4[3])
    );

    assign u2 = {^y2[3], ^y2[2], ^y2[1], ^y2[0]};
    assign u3 = {^y3[3], ^y3[2], ^y3[1], ^y3[0]};
    assign u4 = {^y4[3], ^y4[2], ^y4[1], ^y4[0]};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Fresh multiplier randomness every cycle.
    initial begin
        forever begin
            @(negedge clk);
            r2 = 8'($urandom);
            r3 = 24'($urandom);
            r4 = {16'($urandom), 32'($urandom)};
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [3:0] gmul_ref(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 4; i++)
            if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int i = 6; i >= 4; i--)
            if (((p >> i) & 1) != 0) p = p ^ ('h13 << (i - 4));
        return 4'(p);
    endfunction

    function automatic logic [3:0] inv_ref(input logic [3:0] x);
        logic [3:0] r;
        r = '0;
        for (int y = 1; y < 16; y++)
            if (gmul_ref(int'(x), y) == 4'd1) r = 4'(y);
        return r;
    endfunction

    function automatic logic [3:0] share_bit(input logic b, input int n);
        logic [3:0] r;
        r = 4'($urandom);
        r[n-1] = b;
        for (int i = 0; i < n - 1; i++) r[n-1] = r[n-1] ^ r[i];
        for (int i = n; i < 4; i++) r[i] = 1'b0;
        return r;
    endfunction

    task automatic load(input logic [3:0] v);
        logic [3:0] t;
        for (int i = 0; i < 4; i++) begin
            t = share_bit(v[i], 2); x2[i] = t[1:0];
            t = share_bit(v[i], 3); x3[i] = t[2:0];
            t = share_bit(v[i], 4); x4[i] = t;
        end
    endtask

    task automatic run_one(input logic [3:0] v);
        int n;
        load(v);
        in_valid = 1'b1;
        check("idle_ready", {ir2, ir3, ir4}, 3'b111);
        n = 0;
        do begin
            step();
            n++;
            in_valid = 1'b0;
            if (n == 3) check("busy_ready", {ir2, ir3, ir4}, 3'b000);
        end while (!ov2 && n < 20);
        check("latency", 64'(n), 64'd6);
        check("valid_sync", {ov3, ov4}, 2'b11);
        check("inv_d2", u2, inv_ref(v));
        check("inv_d3", u3, inv_ref(v));
        check("inv_d4", u4, inv_ref(v));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [3:0]       v;
        logic [3:0][1:0]  held;
        logic [3:0]       q[$];
        int               n, cyc, last, nres, seen;
        logic             acc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        load(4'd0);
        step(); step();
        check("rst_ready", ir2, 1'b1);
        check("rst_valid", {ov2, ov3, ov4}, 3'b000);
        check("rst_out", {y2, y3, y4}, 64'd0);
        rst = 1'b0;
        step();
        check("post_rst_ready", ir2, 1'b1);

        run_one(4'd2);
        check("x2_is_9", u2, 64'h9);
        run_one(4'd1);
        check("x1_is_1", u2, 64'h1);
        run_one(4'd3);
        check("x3_is_e", u2, 64'he);

        for (int x = 0; x < 16; x++) run_one(4'(x));

        // Hold in DONE; out_ready is pulsed high while busy and must be ignored.
        v = 4'($urandom_range(1, 15));
        load(v);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (!ov2 && n < 20) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        check("hold_reach", 64'(n), 64'd5);
        check("hold_val", u2, inv_ref(v));
        held = y2;
        in_valid = 1'b1;
        load(4'($urandom));
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_valid", ov2, 1'b1);
            check("hold_ready", ir2, 1'b0);
            check("hold_shares", y2, held);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("release_valid", ov2, 1'b0);
        check("release_ready", ir2, 1'b1);

        // Back-to-back stream with both handshakes held high.
        cyc = 0; last = 0; nres = 0; seen = 0;
        v = 4'($urandom);
        load(v);
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (nres < 5 && cyc < 200) begin
            acc = 1'b0;
            if (ir2) begin
                if (seen > 0) check("stream_gap", 64'(cyc - last), 64'd7);
                last = cyc;
                q.push_back(v);
                seen++;
                acc = 1'b1;
            end
            if (ov2) begin
                if (q.size() == 0) check("stream_spurious", 1'b1, 1'b0);
                else check("stream_out", u2, inv_ref(q.pop_front()));
                nres++;
            end
            step();
            cyc++;
            if (acc) begin
                v = 4'($urandom);
                load(v);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("stream_count", 64'(nres), 64'd5);

        // Abort in M2A: accept edge plus three more edges.
        step();
        load(4'd7);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        check("abort_pre_valid", ov2, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_valid", {ov2, ov3, ov4}, 3'b000);
        check("abort_ready", ir2, 1'b1);
        check("abort_out", {y2, y3, y4}, 64'd0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (ov2) n++;
        end
        check("abort_no_result", 64'(n), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
